// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch and data requesters.
// Data has priority; a starvation counter forces a fetch after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner;        // 0 = fetch, 1 = data
  logic [3:0] starve_cnt;
  logic       pick_fetch;

  assign pick_fetch = if_req & (~dm_req | (starve_cnt == 4'(STARVE_MAX)));
  assign stall_if   = if_req & ~if_ack;
  assign stall_mem  = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state   <= ISSUE;
            mem_req <= 1'b1;
            owner   <= ~pick_fetch;
            if (pick_fetch) begin
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              mem_be     <= 4'hF;
              starve_cnt <= '0;
            end else begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_be    <= dm_be;
              // data only wins a contested slot while the count is below the limit
              starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (owner) begin
              dm_rdata <= mem_rdata;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation, store, reset and drop cases.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acts as memory for one transaction; returns in the cycle the ack should be visible.
  task automatic serve(input string tag, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int gdly, input logic [31:0] rd);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_we"}, 32'(mem_we), 32'(we));
      chk({tag, "_be"}, 32'(mem_be), 32'(be));
      chk({tag, "_wdata"}, mem_wdata, wd);
      if (i < gdly) tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; dm_be = 0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // fetch only, best-case latency
    if_req = 1; if_addr = 32'h100;
    #1 chk("f_stall_c0", 32'(stall_if), 32'd1);
    tick();
    chk("f_mem_req_c1", 32'(mem_req), 32'd1);
    chk("f_addr_c1", mem_addr, 32'h100);
    chk("f_be_c1", 32'(mem_be), 32'hF);
    chk("f_stall_c1", 32'(stall_if), 32'd1);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("f_mem_req_c2", 32'(mem_req), 32'd0);
    chk("f_stall_c2", 32'(stall_if), 32'd1);
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    tick();
    mem_rvalid = 0;
    chk("f_ack_c3", 32'(if_ack), 32'd1);
    chk("f_rdata_c3", if_rdata, 32'h00500093);
    chk("f_stall_c3", 32'(stall_if), 32'd0);
    if_req = 0;
    tick();
    chk("f_ack_c4", 32'(if_ack), 32'd0);

    // simultaneous: data first, then fetch
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = 4'hF; dm_wdata = 32'h0;
    #1 chk("s_stall_mem", 32'(stall_mem), 32'd1);
    serve("s_data", 32'h2000, 1'b0, 4'hF, 32'h0, 0, 32'h12345678);
    chk("s_dm_ack", 32'(dm_ack), 32'd1);
    chk("s_dm_rdata", dm_rdata, 32'h12345678);
    chk("s_stall_if", 32'(stall_if), 32'd1);
    chk("s_stall_mem_ack", 32'(stall_mem), 32'd0);
    dm_req = 0;
    serve("s_fetch", 32'h104, 1'b0, 4'hF, 32'h0, 0, 32'h00100073);
    chk("s_if_ack", 32'(if_ack), 32'd1);
    chk("s_if_rdata", if_rdata, 32'h00100073);
    if_req = 0;
    tick();

    // starvation: four data grants, then a forced fetch
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000; dm_be = 4'h5; dm_wdata = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      serve("st_data", 32'h3000, 1'b0, 4'h5, 32'h11111111, 0, 32'h100 + 32'(k));
      chk("st_dm_ack", 32'(dm_ack), 32'd1);
      chk("st_if_ack_lo", 32'(if_ack), 32'd0);
    end
    serve("st_fetch", 32'h200, 1'b0, 4'hF, 32'h0, 0, 32'hAAAA5555);
    chk("st_if_ack", 32'(if_ack), 32'd1);
    chk("st_if_rdata", if_rdata, 32'hAAAA5555);
    chk("st_dm_rdata_hold", dm_rdata, 32'h103);
    if_addr = 32'h204;
    serve("st_after", 32'h3000, 1'b0, 4'h5, 32'h11111111, 0, 32'h0);
    chk("st_after_ack", 32'(dm_ack), 32'd1);
    dm_req = 0; if_req = 0;
    tick();

    // stray rvalid in IDLE is ignored
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 0;
    tick();
    chk("rv_idle_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("rv_idle_req", 32'(mem_req), 32'd0);

    // store with grant delayed three cycles
    dm_req = 1; dm_we = 1; dm_addr = 32'h4000; dm_be = 4'b0011; dm_wdata = 32'hDEADBEEF;
    serve("w", 32'h4000, 1'b1, 4'b0011, 32'hDEADBEEF, 3, 32'h0000BEEF);
    chk("w_dm_ack", 32'(dm_ack), 32'd1);
    chk("w_dm_rdata", dm_rdata, 32'h0000BEEF);
    dm_req = 0; dm_we = 0;
    tick();
    chk("w_ack_once", 32'(dm_ack), 32'd0);

    // reset asserted in WAIT
    if_req = 1; if_addr = 32'h300;
    tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    reset = 1'b0;
    #1;
    chk("r_mem_req", 32'(mem_req), 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
    chk("r_if_rdata", if_rdata, 32'd0);
    chk("r_dm_rdata", dm_rdata, 32'd0);
    if_req = 0;
    @(negedge clk) reset = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'h55555555;
    tick();
    mem_rvalid = 0;
    chk("r_late_ack", {30'd0, if_ack, dm_ack}, 32'd0);
    tick();
    chk("r_late_ack2", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("r_late_rdata", if_rdata, 32'd0);

    // fetch dropped while waiting still completes exactly once
    if_req = 1; if_addr = 32'h400;
    tick();
    chk("d_mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    if_req = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 0;
    chk("d_if_ack", 32'(if_ack), 32'd1);
    chk("d_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("d_stall_if", 32'(stall_if), 32'd0);
    tick();
    chk("d_if_ack_lo", 32'(if_ack), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("d_no_reissue", 32'(mem_req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
